// File: rtl/vrf_wr_arbiter.sv
// Fixed-priority ALU/LSU arbiter for the single vector register file write port.
// Define VRF_WR_ARBITER_STATS_EN to add the write/conflict statistics counters.
module vrf_wr_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             alu_req,
  input  logic [4:0]       alu_wa,
  input  logic [63:0]      alu_wd,
  output logic             alu_gnt,
  input  logic             lsu_req,
  input  logic [4:0]       lsu_wa,
  input  logic [63:0]      lsu_wd,
  output logic             lsu_gnt,
  output logic             wen,
  output logic [4:0]       wa,
  output logic [63:0]      wd,
  output logic             lsu_forced
`ifdef VRF_WR_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0] alu_wr_cnt,
  output logic [CNT_W-1:0] lsu_wr_cnt,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0]  r_starve;
  logic        r_wen;
  logic [4:0]  r_wa;
  logic [63:0] r_wd;
  logic        w_ok;
  logic        w_force;

  // Grants are masked by reset so nothing is accepted while it is held.
  assign w_ok    = !rst && !stall;
  assign w_force = w_ok && lsu_req && (r_starve >= LIM);
  assign alu_gnt = w_ok && alu_req && !w_force;
  assign lsu_gnt = w_ok && lsu_req && (w_force || !alu_req);
  assign lsu_forced = w_force;

  assign wen = r_wen;
  assign wa  = r_wa;
  assign wd  = r_wd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (lsu_gnt) begin
      r_starve <= '0;
    end else if (w_ok && lsu_req && r_starve != 4'hF) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen <= 1'b0;
      r_wa  <= '0;
      r_wd  <= '0;
    end else begin
      r_wen <= alu_gnt || lsu_gnt;
      if (alu_gnt) begin
        r_wa <= alu_wa;
        r_wd <= alu_wd;
      end else if (lsu_gnt) begin
        r_wa <= lsu_wa;
        r_wd <= lsu_wd;
      end
    end
  end

`ifdef VRF_WR_ARBITER_STATS_EN
  logic [CNT_W-1:0] r_alu_cnt;
  logic [CNT_W-1:0] r_lsu_cnt;
  logic [CNT_W-1:0] r_conf_cnt;

  assign alu_wr_cnt   = r_alu_cnt;
  assign lsu_wr_cnt   = r_lsu_cnt;
  assign conflict_cnt = r_conf_cnt;

  // All statistics counters saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_cnt  <= '0;
      r_lsu_cnt  <= '0;
      r_conf_cnt <= '0;
    end else begin
      if (alu_gnt && r_alu_cnt != '1)
        r_alu_cnt <= r_alu_cnt + CNT_W'(1);
      if (lsu_gnt && r_lsu_cnt != '1)
        r_lsu_cnt <= r_lsu_cnt + CNT_W'(1);
      if (w_ok && alu_req && lsu_req && r_conf_cnt != '1)
        r_conf_cnt <= r_conf_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vrf_wr_arbiter.sv
// Scoreboard bench for vrf_wr_arbiter: directed scenarios plus
// randomized traffic checked against a rule-level reference model.
module tb_vrf_wr_arbiter;

  localparam int LIM   = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        alu_req = 1'b0;
  logic [4:0]  alu_wa = '0;
  logic [63:0] alu_wd = '0;
  logic        alu_gnt;
  logic        lsu_req = 1'b0;
  logic [4:0]  lsu_wa = '0;
  logic [63:0] lsu_wd = '0;
  logic        lsu_gnt;
  logic        wen;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic        lsu_forced;
`ifdef VRF_WR_ARBITER_STATS_EN
  logic [CNT_W-1:0] alu_wr_cnt;
  logic [CNT_W-1:0] lsu_wr_cnt;
  logic [CNT_W-1:0] conflict_cnt;
`endif

  vrf_wr_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .alu_req(alu_req), .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_gnt(alu_gnt),
    .lsu_req(lsu_req), .lsu_wa(lsu_wa), .lsu_wd(lsu_wd), .lsu_gnt(lsu_gnt),
    .wen(wen), .wa(wa), .wd(wd), .lsu_forced(lsu_forced)
`ifdef VRF_WR_ARBITER_STATS_EN
    , .alu_wr_cnt(alu_wr_cnt), .lsu_wr_cnt(lsu_wr_cnt),
    .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  wa;
    logic [63:0] wd;
  } wr_t;

  wr_t         q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          losses = 0;
  int          n_alu = 0, n_lsu = 0, n_conf = 0;
  logic [4:0]  last_wa = '0;
  logic [63:0] last_wd = '0;
  bit          g_a, g_l;
  bit          done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // One arbitration cycle: drive, compare grants to model, queue writes.
  task automatic step(input bit s, input bit a, input logic [4:0] aw,
                      input logic [63:0] ad, input bit l,
                      input logic [4:0] lw, input logic [63:0] ld);
    bit ea, el, ef;
    @(negedge clk);
    stall = s; alu_req = a; alu_wa = aw; alu_wd = ad;
    lsu_req = l; lsu_wa = lw; lsu_wd = ld;
    #1;
    ef = !rst && !s && l && (losses >= LIM);
    ea = !rst && !s && a && !ef;
    el = !rst && !s && l && !ea;
    chk("alu_gnt", 64'(alu_gnt), 64'(ea));
    chk("lsu_gnt", 64'(lsu_gnt), 64'(el));
    chk("lsu_forced", 64'(lsu_forced), 64'(ef));
    if (ea) q.push_back('{cyc + 1, aw, ad});
    if (el) q.push_back('{cyc + 1, lw, ld});
    if (!rst && !s) begin
      if (el) losses = 0;
      else if (l && losses < 15) losses++;
      if (a && l) n_conf++;
    end
    if (ea) n_alu++;
    if (el) n_lsu++;
    g_a = ea;
    g_l = el;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    alu_req = 1'b1;
    lsu_req = 1'b1;
    #1;
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_alu_gnt", 64'(alu_gnt), 64'd0);
    chk("rst_lsu_gnt", 64'(lsu_gnt), 64'd0);
    q.delete();
    losses = 0;
    n_alu = 0; n_lsu = 0; n_conf = 0;
    last_wa = '0;
    last_wd = '0;
    @(negedge clk);
    rst = 1'b0;
    alu_req = 1'b0;
    lsu_req = 1'b0;
  endtask

  // Monitor: every write on the port must match the queue head, on time.
  initial begin
    wr_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_wen_mon", 64'(wen), 64'd0);
        chk("rst_wa", 64'(wa), 64'd0);
        chk("rst_wd", wd, 64'd0);
      end else if (wen) begin
        if (q.size() == 0) begin
          chk("unexpected_write", 64'(wen), 64'd0);
        end else begin
          e = q.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(e.cyc));
          chk("wr_wa", 64'(wa), 64'(e.wa));
          chk("wr_wd", wd, e.wd);
          last_wa = e.wa;
          last_wd = e.wd;
        end
      end else begin
        chk("hold_wa", 64'(wa), 64'(last_wa));
        chk("hold_wd", wd, last_wd);
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          chk("missing_write", 64'(wen), 64'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bit          pa, pl, s;
    logic [4:0]  awa, lwa;
    logic [63:0] awd, lwd;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single ALU request.
    step(0, 1, 5'd3, 64'hDEADBEEF_00000001, 0, '0, '0);
    idle(2);

    // Continuous contention: A,A,A,A,L(forced) repeating.
    awa = 5'd1; awd = 64'h100; lwa = 5'd2; lwd = 64'h200;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, awa, awd, 1, lwa, lwd);
      chk("contend_pat", 64'(lsu_gnt), 64'((i % 5) == 4));
      if (g_a) begin awa++; awd++; end
      if (g_l) begin lwa++; lwd++; end
    end
    idle(1);

    // Stall with both requesting, then release: ALU first.
    for (int i = 0; i < 3; i++) step(1, 1, 5'd4, 64'h44, 1, 5'd5, 64'h55);
    step(0, 1, 5'd4, 64'h44, 1, 5'd5, 64'h55);
    chk("stall_release_alu", 64'(alu_gnt), 64'd1);
    step(0, 0, '0, '0, 1, 5'd5, 64'h55);
    idle(1);

    // Same destination: ALU writes first, LSU value lands last.
    step(0, 1, 5'd7, 64'd1, 1, 5'd7, 64'd2);
    step(0, 0, '0, '0, 1, 5'd7, 64'd2);
    idle(2);
    chk("same_addr_last_wa", 64'(wa), 64'd7);
    chk("same_addr_last_wd", wd, 64'd2);

    // Reset one cycle after an ALU grant.
    step(0, 1, 5'd9, 64'h99, 0, '0, '0);
    reset_pulse();
    idle(3);

    // Randomized traffic with hold-until-grant requesters.
    pa = 0; pl = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pa) begin
        pa = $urandom_range(0, 99) < 60;
        awa = 5'($urandom);
        awd = {$urandom, $urandom};
      end else if ($urandom_range(0, 99) < 5) pa = 0;
      if (!pl) begin
        pl = $urandom_range(0, 99) < 70;
        lwa = 5'($urandom);
        lwd = {$urandom, $urandom};
      end else if ($urandom_range(0, 99) < 5) pl = 0;
      s = $urandom_range(0, 99) < 15;
      step(s, pa, awa, awd, pl, lwa, lwd);
      if (g_a) pa = 0;
      if (g_l) pl = 0;
    end
    idle(4);
    chk("queue_drained", 64'(q.size()), 64'd0);

`ifdef VRF_WR_ARBITER_STATS_EN
    chk("alu_wr_cnt", 64'(alu_wr_cnt), 64'(n_alu));
    chk("lsu_wr_cnt", 64'(lsu_wr_cnt), 64'(n_lsu));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(n_conf));
    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 5'(i), 64'(i), 1, 5'd20, 64'h20);
    end
    step(0, 1, 5'd3, 64'd3, 0, '0, '0);
    step(0, 1, 5'd4, 64'd4, 0, '0, '0);
    step(0, 0, '0, '0, 1, 5'd20, 64'h20);
    step(0, 0, '0, '0, 1, 5'd21, 64'h21);
    idle(2);
    chk("alu_wr_cnt_5", 64'(alu_wr_cnt), 64'd5);
    chk("lsu_wr_cnt_2", 64'(lsu_wr_cnt), 64'd2);
    chk("conflict_cnt_3", 64'(conflict_cnt), 64'd3);
`endif

    done = 1;
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vrf_wr_arbiter.md
Name: vrf_wr_arbiter

Overview:
- Shares the single vector register file write port (5-bit address, 64-bit data, write enable) between two requesters: the vector ALU and the vector load/store unit (LSU).
- Fixed priority, ALU over LSU. A starvation counter forces an LSU grant after a bounded number of consecutive losses.
- Write outputs are registered and drive the register file write port directly.
- Sits between the execute/memory stages and the vector register file.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles the LSU may request and lose before it gets forced priority (legal range 1..15).
- CNT_W, 16: width of the statistics counters (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- stall  input  1  register file write port unavailable; no grants while high.
- alu_req  input  1  ALU write request.
- alu_wa  input  5  ALU destination register.
- alu_wd  input  64  ALU write data.
- alu_gnt  output  1  ALU request accepted this cycle (combinational).
- lsu_req  input  1  LSU write request.
- lsu_wa  input  5  LSU destination register.
- lsu_wd  input  64  LSU write data.
- lsu_gnt  output  1  LSU request accepted this cycle (combinational).
- wen  output  1  register file write enable (registered).
- wa  output  5  register file write address (registered).
- wd  output  64  register file write data (registered).
- lsu_forced  output  1  high in any cycle where the LSU grant came from starvation override.

Behaviour:
- Reset (asynchronous, active-high): wen=0, wa=0, wd=0, starvation counter=0, stats counters=0. Grants are combinational, so they are 0 while rst is high.
- Handshake:
  - A requester holds req, wa and wd stable until it sees gnt high. The transfer occurs in the cycle where req and gnt are both high.
  - Dropping req before gnt is legal; the request is simply withdrawn.
- Grant logic:
  - stall=1: alu_gnt=lsu_gnt=0.
  - Otherwise, starve_cnt >= STARVE_LIMIT and lsu_req=1: lsu_gnt=1, alu_gnt=0, lsu_forced=1.
  - Otherwise, alu_req=1: alu_gnt=1.
  - Otherwise, lsu_req=1: lsu_gnt=1.
- At most one grant per cycle (one-hot or zero).
- Latency: a request granted in cycle N appears on wen/wa/wd in cycle N+1. In cycles with no grant, wen=0 and wa/wd hold their previous values.
- Starvation counter (4 bits):
  - Increments when lsu_req=1, lsu_gnt=0 and stall=0.
  - Clears on lsu_gnt.
  - Holds when stall=1 or lsu_req=0 and saturates at 15.
  - A stall does not count as a loss.
- Same destination register from both requesters in the same cycle: the winner writes first and the loser writes in a later cycle. The final register value equals the last write (no merging).
- Data is never modified; wa and wd pass through bit-exact.
- Reset asserted mid-operation: a pending registered write is discarded (wen drops immediately) and the counter clears. Requesters must re-present their requests after reset.

Optional Feature:
- Macro: VRF_WR_ARBITER_STATS_EN.
- When defined, adds outputs alu_wr_cnt [CNT_W-1:0], lsu_wr_cnt [CNT_W-1:0] and conflict_cnt [CNT_W-1:0]:
  - alu_wr_cnt and lsu_wr_cnt count accepted writes per requester.
  - conflict_cnt counts cycles with alu_req=lsu_req=1 and stall=0.
  - All three saturate at all-ones and reset to 0.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Single requester: alu_req with wa=3, wd=0xDEADBEEF_00000001 in cycle 0 → alu_gnt=1 in cycle 0; wen=1, wa=3, wd=0xDEADBEEF_00000001 in cycle 1; wen=0 in cycle 2.
- Contention: both requesters held continuously, STARVE_LIMIT=4 → grant sequence A,A,A,A,L(forced, lsu_forced=1), then A,A,A,A,L repeating.
- Stall: both requesting with stall=1 for 3 cycles → no grants, wen=0, starvation counter unchanged. On stall release, ALU is granted first.
- Same address: ALU wa=7 wd=1, LSU wa=7 wd=2 in the same cycle → ALU write in cycle 1, LSU write in cycle 2, wa=7 with wd=2 last.
- Reset mid-transfer: rst pulsed for 1 cycle on the cycle after an ALU grant → wen=0 immediately, counter=0, no write appears after reset deasserts.
- Stats (macro defined): 5 ALU writes, 2 LSU writes, 3 conflict cycles → alu_wr_cnt=5, lsu_wr_cnt=2, conflict_cnt=3.
